// File: rtl/img_readout_chunker_pkg.sv
// Shared types and sizing constants for the readout chunker.
package img_readout_chunker_pkg;

    // An SD block is 512 bytes and each readout word carries two bytes.
    localparam int SD_BLOCK_BYTES      = 512;
    localparam int WORD_BYTES          = 2;
    localparam int CHUNK_WORDS_DEFAULT = SD_BLOCK_BYTES / WORD_BYTES;

    // Width of the delivered-chunk status counter.
    localparam int STATUS_W = 16;

    // Read-side sequencer states.
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_VALID = 2'd2
    } rd_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/img_readout_chunker_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module img_readout_chunker_ram #(
    parameter int Depth     = 512,
    parameter int AddrWidth = 9,
    parameter int DataWidth = 16
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [DataWidth-1:0] rd_data
);

    logic [DataWidth-1:0] mem [Depth];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port, one cycle of latency.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/img_readout_chunker.sv
// Buffers the imager readout stream into whole chunks and hands only complete
// chunks to the SD-side consumer.
module img_readout_chunker
    import img_readout_chunker_pkg::*;
#(
    parameter int ChunkWords = CHUNK_WORDS_DEFAULT,
    parameter int ChunkCount = 2,
    parameter int WordWidth  = 16
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 readout_start,
    input  logic                 readout_ready,
    output logic                 readout_trigger,
    input  logic [WordWidth-1:0] readout_data,
    output logic                 out_chunkReady,
    output logic                 out_ready,
    input  logic                 out_trigger,
    output logic [WordWidth-1:0] out_data,
    output logic                 out_last,
    output logic [STATUS_W-1:0]  status_chunkCount
);

    localparam int Depth = ChunkWords * ChunkCount;
    localparam int AW    = log2_ceil(Depth);
    localparam int LW    = log2_ceil(ChunkWords);
    localparam int FW    = log2_ceil(ChunkCount) + 1;
    localparam logic [LW-1:0] LAST_IDX = LW'(ChunkWords - 1);

    logic [AW-1:0]          wptr_reg, rptr_reg, rptr_next, rd_addr;
    logic [FW-1:0]          filled_reg, filled_next;
    rd_state_t              state_reg, state_next;
    logic                   out_ready_reg, out_ready_next;
    logic                   out_last_reg, out_last_next;
    logic                   trigger_reg, chunk_ready_reg;
    logic [STATUS_W-1:0]    status_reg;
    logic [WordWidth-1:0]   ram_rd_data;
    logic                   wr_fire, wr_done, rd_done;

    // A write that lands on the last slot of a chunk completes that chunk.
    assign wr_fire = readout_ready && trigger_reg;
    assign wr_done = wr_fire && (wptr_reg[LW-1:0] == LAST_IDX);

    // The RAM output register is presented directly; the read address is
    // steered so it holds the current word or prefetches the next one.
    img_readout_chunker_ram #(
        .Depth     (Depth),
        .AddrWidth (AW),
        .DataWidth (WordWidth)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire && !readout_start),
        .wr_addr (wptr_reg),
        .wr_data (readout_data),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Read sequencer: next state, read address and output flags.
    always_comb begin
        state_next     = state_reg;
        rptr_next      = rptr_reg;
        rd_addr        = rptr_reg;
        out_ready_next = out_ready_reg;
        out_last_next  = out_last_reg;
        rd_done        = 1'b0;
        unique case (state_reg)
            R_IDLE: begin
                if (filled_reg != '0) begin
                    state_next = R_FETCH;
                end
            end
            R_FETCH: begin
                out_ready_next = 1'b1;
                out_last_next  = (rptr_reg[LW-1:0] == LAST_IDX);
                state_next     = R_VALID;
            end
            R_VALID: begin
                if (out_trigger) begin
                    rptr_next = rptr_reg + AW'(1);
                    if (out_last_reg) begin
                        rd_done        = 1'b1;
                        out_ready_next = 1'b0;
                        out_last_next  = 1'b0;
                        state_next     = R_IDLE;
                    end else begin
                        rd_addr       = rptr_next;
                        out_last_next = (rptr_next[LW-1:0] == LAST_IDX);
                    end
                end
            end
            default: begin
                state_next = R_IDLE;
            end
        endcase
    end

    // Complete-chunk occupancy; simultaneous fill and drain cancel out.
    always_comb begin
        filled_next = filled_reg;
        if (wr_done && !rd_done) begin
            filled_next = filled_reg + FW'(1);
        end else if (rd_done && !wr_done) begin
            filled_next = filled_reg - FW'(1);
        end
    end

    // State registers; readout_start flushes everything and beats any transfer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_reg        <= '0;
            rptr_reg        <= '0;
            filled_reg      <= '0;
            state_reg       <= R_IDLE;
            out_ready_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            trigger_reg     <= 1'b0;
            chunk_ready_reg <= 1'b0;
            status_reg      <= '0;
        end else if (readout_start) begin
            wptr_reg        <= '0;
            rptr_reg        <= '0;
            filled_reg      <= '0;
            state_reg       <= R_IDLE;
            out_ready_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            trigger_reg     <= 1'b1;
            chunk_ready_reg <= 1'b0;
            status_reg      <= '0;
        end else begin
            if (wr_fire) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            rptr_reg        <= rptr_next;
            filled_reg      <= filled_next;
            state_reg       <= state_next;
            out_ready_reg   <= out_ready_next;
            out_last_reg    <= out_last_next;
            trigger_reg     <= (filled_next < FW'(ChunkCount));
            chunk_ready_reg <= (filled_next != '0);
            if (rd_done && (status_reg != '1)) begin
                status_reg <= status_reg + STATUS_W'(1);
            end
        end
    end

    assign readout_trigger   = trigger_reg;
    assign out_chunkReady    = chunk_ready_reg;
    assign out_ready         = out_ready_reg;
    assign out_last          = out_last_reg;
    assign out_data          = out_ready_reg ? ram_rd_data : '0;
    assign status_chunkCount = status_reg;

endmodule

// File: tb/tb_img_readout_chunker.sv
// Self-checking bench for img_readout_chunker against a queue-based model.
module tb_img_readout_chunker;

    localparam int CW = 256;

    logic        clk = 1'b0;
    logic        rst_;
    logic        readout_start;
    logic        readout_ready;
    logic        readout_trigger;
    logic [15:0] readout_data;
    logic        out_chunkReady;
    logic        out_ready;
    logic        out_trigger;
    logic [15:0] out_data;
    logic        out_last;
    logic [15:0] status_chunkCount;

    img_readout_chunker dut (
        .clk               (clk),
        .rst_              (rst_),
        .readout_start     (readout_start),
        .readout_ready     (readout_ready),
        .readout_trigger   (readout_trigger),
        .readout_data      (readout_data),
        .out_chunkReady    (out_chunkReady),
        .out_ready         (out_ready),
        .out_trigger       (out_trigger),
        .out_data          (out_data),
        .out_last          (out_last),
        .status_chunkCount (status_chunkCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted word in order, plus word counters
    // since the last flush. Whole chunks are derived by division.
    logic [15:0] exp_q[$];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    bit          gap_watch = 1'b0;
    int          gap_len = 0;

    typedef struct {
        int          n_words;
        logic [15:0] base;
        bit          down;
        int          rr_pct;
        int          ot_pct;
        int          exp_status;
        bit          exp_chunk_ready;
        bit          exp_trigger;
    } phase_t;

    phase_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        wr_cnt    = 0;
        rd_cnt    = 0;
        gap_watch = 1'b0;
        gap_len   = 0;
    endtask

    // Compare DUT outputs with what the model says should be visible now.
    task automatic model_check();
        int full;
        int delivered;
        full      = wr_cnt / CW - rd_cnt / CW;
        delivered = rd_cnt / CW;
        chk("chunk_ready", out_chunkReady, full != 0);
        chk("readout_trigger", readout_trigger, full < 2);
        chk("status", status_chunkCount, (delivered > 65535) ? 65535 : delivered);
        if (out_ready) begin
            if (exp_q.size() == 0 || full == 0) begin
                chk("out_ready_spurious", out_ready, 0);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", out_last, (rd_cnt % CW) == CW - 1);
            end
        end
        if (gap_watch) begin
            if (out_ready) begin
                chk("chunk_gap", gap_len >= 2, 1);
                gap_watch = 1'b0;
            end else begin
                gap_len++;
            end
        end
    endtask

    // One clock: check at the falling edge, then drive inputs for the next
    // rising edge and record what the model expects that edge to transfer.
    task automatic cycle(input logic st, input logic rr, input logic [15:0] d,
                         input logic ot, output bit wacc);
        @(negedge clk);
        model_check();
        readout_start = st;
        readout_ready = rr;
        readout_data  = d;
        out_trigger   = ot;
        wacc = 1'b0;
        if (st) begin
            model_clear();
        end else begin
            if (rr && readout_trigger) begin
                exp_q.push_back(d);
                wr_cnt++;
                wacc = 1'b1;
            end
            if (ot && out_ready && exp_q.size() != 0) begin
                if ((rd_cnt % CW) == CW - 1) begin
                    gap_watch = 1'b1;
                    gap_len   = 0;
                end
                void'(exp_q.pop_front());
                rd_cnt++;
            end
        end
    endtask

    task automatic write_words(input int n, input logic [15:0] base, input bit down,
                               input int rr_pct, input int ot_pct);
        int  sent;
        int  budget;
        bit  acc;
        logic [15:0] d;
        sent   = 0;
        budget = 0;
        while (sent < n && budget < 20000) begin
            d = down ? base - 16'(sent) : base + 16'(sent);
            cycle(1'b0, $urandom_range(99) < rr_pct, d, $urandom_range(99) < ot_pct, acc);
            if (acc) sent++;
            budget++;
        end
        chk("write_budget", sent, n);
    endtask

    task automatic drain(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 1'b0, 16'h0, 1'b1, acc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_trigger"}, readout_trigger, 0);
        chk({tag, "_chunk_ready"}, out_chunkReady, 0);
        chk({tag, "_out_ready"}, out_ready, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_status"}, status_chunkCount, 0);
    endtask

    initial begin
        bit acc;
        int guard;

        tbl[0] = '{768,  16'h0FFF, 1'b1, 50,  50,  3, 1'b0, 1'b1};
        tbl[1] = '{300,  16'h1000, 1'b0, 100, 100, 1, 1'b0, 1'b1};
        tbl[2] = '{256,  16'h4000, 1'b0, 30,  80,  1, 1'b0, 1'b1};
        tbl[3] = '{1024, 16'h8000, 1'b0, 90,  20,  4, 1'b0, 1'b1};

        rst_          = 1'b0;
        readout_start = 1'b0;
        readout_ready = 1'b0;
        readout_data  = 16'h0;
        out_trigger   = 1'b0;
        #23;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_ = 1'b1;
        model_clear();

        // Fill both chunks with no reader, then drain in order.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
        write_words(512, 16'h0000, 1'b0, 100, 0);
        repeat (20) begin
            cycle(1'b0, 1'b1, 16'hBEEF, 1'b0, acc);
            chk("full_no_accept", acc, 0);
        end
        drain(1100);
        chk("fill_drain_status", status_chunkCount, 2);
        chk("fill_drain_trigger", readout_trigger, 1);
        $display("fill_drain: status=%0d", status_chunkCount);

        // First-word latency after a chunk completes while the reader is idle.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
        write_words(256, 16'h3000, 1'b0, 100, 0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
        chk("lat_n1_chunk_ready", out_chunkReady, 1);
        chk("lat_n1_out_ready", out_ready, 0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
        chk("lat_n2_out_ready", out_ready, 0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
        chk("lat_n3_out_ready", out_ready, 1);
        chk("lat_n3_out_data", out_data, 16'h3000);
        drain(400);
        $display("latency: status=%0d", status_chunkCount);

        // Table of randomized phases, each opened by a flush.
        foreach (tbl[i]) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
            write_words(tbl[i].n_words, tbl[i].base, tbl[i].down, tbl[i].rr_pct, tbl[i].ot_pct);
            drain(1000);
            chk("phase_status", status_chunkCount, tbl[i].exp_status);
            chk("phase_chunk_ready", out_chunkReady, tbl[i].exp_chunk_ready);
            chk("phase_trigger", readout_trigger, tbl[i].exp_trigger);
            // Flushed remainder must never be emitted.
            cycle(1'b1, 1'b0, 16'h0, 1'b1, acc);
            drain(50);
            chk("post_flush_out_ready", out_ready, 0);
            $display("phase %0d: words=%0d status=%0d", i, tbl[i].n_words, status_chunkCount);
        end

        // Last write of chunk 1 and last accept of chunk 0 on the same edge.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
        write_words(511, 16'h2000, 1'b0, 100, 0);
        guard = 0;
        while (rd_cnt < CW - 1 && guard < 2000) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b1, acc);
            guard++;
        end
        chk("same_edge_reach", rd_cnt, CW - 1);
        cycle(1'b0, 1'b1, 16'h21FF, 1'b1, acc);
        chk("same_edge_last_shown", out_last, 1);
        chk("same_edge_write_acc", acc, 1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
        chk("same_edge_chunk_ready", out_chunkReady, 1);
        chk("same_edge_status", status_chunkCount, 1);
        drain(400);
        chk("same_edge_final_status", status_chunkCount, 2);
        $display("same_edge: status=%0d", status_chunkCount);

        // Asynchronous reset while a chunk is being read.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
        write_words(256, 16'h5000, 1'b0, 100, 0);
        repeat (10) cycle(1'b0, 1'b0, 16'h0, 1'b1, acc);
        chk("pre_reset_reading", out_ready, 1);
        #2;
        rst_ = 1'b0;
        #1;
        chk_reset_outputs("async");
        readout_start = 1'b0;
        readout_ready = 1'b0;
        out_trigger   = 1'b0;
        model_clear();
        @(negedge clk);
        rst_ = 1'b1;
        write_words(256, 16'h6000, 1'b0, 70, 60);
        drain(600);
        chk("post_reset_status", status_chunkCount, 1);
        $display("async_reset: status=%0d", status_chunkCount);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
